// File: rtl/brick_wall_engine.sv
// Brick wall for breakout: per-frame ball hit test over a ROWS x COLS grid, optional wall drop, erase/draw pixel stream.
// Defining BRICK_SCORE_EN adds a saturating destroyed-brick counter on port score.
module brick_wall_engine #(
  parameter int COLS       = 5,
  parameter int ROWS       = 1,
  parameter int BRICK_W    = 8,
  parameter int BRICK_H    = 2,
  parameter int X0         = 15,
  parameter int Y0         = 30,
  parameter int X_PITCH    = 30,
  parameter int Y_PITCH    = 6,
  parameter int HITS       = 1,
  parameter int LOWER_STEP = 10,
  parameter int FLOOR_Y    = 108,
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic [7:0]  ball_x,
  input  logic [7:0]  ball_y,
  input  logic        lower,
  input  logic        plot_ready,
  output logic        plot_valid,
  output logic [7:0]  plot_x,
  output logic [7:0]  plot_y,
  output logic [2:0]  plot_colour,
  output logic        bounce,
  output logic [7:0]  bricks_left,
  output logic        wall_reached,
  output logic        busy,
`ifdef BRICK_SCORE_EN
  output logic [15:0] score,
`endif
  output logic        done
);
  localparam int N   = ROWS * COLS;
  localparam int IW  = (N > 1) ? $clog2(N) : 1;
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int PXW = $clog2(BRICK_W);
  localparam int PYW = (BRICK_H > 1) ? $clog2(BRICK_H) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_ERASE = 3'd2;
  localparam logic [2:0] S_DRAW  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  function automatic logic [2:0] colour_of(input logic [1:0] h);
    case (h)
      2'd0:    colour_of = 3'b000;
      2'd1:    colour_of = 3'b010;
      2'd2:    colour_of = 3'b110;
      default: colour_of = 3'b100;
    endcase
  endfunction

  logic [2:0]     state_q, state_d;
  logic [1:0]     hits_q [N];
  logic [1:0]     hits_d [N];
  logic [7:0]     offset_q, offset_d, ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic           lower_q, lower_d;
  logic [IW-1:0]  idx_q, idx_d, nxt_idx_s;
  logic [RW-1:0]  row_q, row_d, nxt_row_s;
  logic [CW-1:0]  col_q, col_d, nxt_col_s;
  logic [PXW-1:0] px_q, px_d;
  logic [PYW-1:0] py_q, py_d;
  logic           plot_valid_q, plot_valid_d;
  logic [7:0]     plot_x_q, plot_x_d, plot_y_q, plot_y_d;
  logic [2:0]     plot_colour_q, plot_colour_d;
  logic           bounce_q, bounce_d, wall_q, wall_d, busy_q, busy_d, done_q, done_d;
  logic [7:0]     left_q, left_d;
`ifdef BRICK_SCORE_EN
  logic [15:0]    score_q, score_d;
  assign score = score_q;
`endif

  logic [9:0] bx_s, by_s, pix_x_s, pix_y_s;
  logic [1:0] cur_hits_s;
  logic [8:0] offset_sum_s;
  logic       hit_s, last_brick_s, last_px_s, can_adv_s, on_screen_s, reach_s;

  assign plot_valid   = plot_valid_q;
  assign plot_x       = plot_x_q;
  assign plot_y       = plot_y_q;
  assign plot_colour  = plot_colour_q;
  assign bounce       = bounce_q;
  assign bricks_left  = left_q;
  assign wall_reached = wall_q;
  assign busy         = busy_q;
  assign done         = done_q;

  // Geometry of the brick/pixel under the cursor, hit test and the wall-floor test.
  always_comb begin
    bx_s         = 10'(X0) + 10'(col_q) * 10'(X_PITCH);
    by_s         = 10'(Y0) + 10'(row_q) * 10'(Y_PITCH) + {2'b00, offset_q};
    pix_x_s      = bx_s + 10'(px_q);
    pix_y_s      = by_s + 10'(py_q);
    cur_hits_s   = hits_q[idx_q];
    hit_s        = (cur_hits_s != 2'd0) && !bounce_q &&
                   ({2'b00, ball_x_q} >= bx_s) && ({2'b00, ball_x_q} < bx_s + 10'(BRICK_W)) &&
                   ({2'b00, ball_y_q} >= by_s) && ({2'b00, ball_y_q} < by_s + 10'(BRICK_H));
    on_screen_s  = (pix_x_s < 10'(SCREEN_W)) && (pix_y_s < 10'(SCREEN_H));
    last_brick_s = (idx_q == IW'(N - 1));
    last_px_s    = (px_q == PXW'(BRICK_W - 1)) && (py_q == PYW'(BRICK_H - 1));
    can_adv_s    = !plot_valid_q || plot_ready;
    offset_sum_s = {1'b0, offset_q} + 9'(LOWER_STEP);
    nxt_idx_s    = idx_q + IW'(1);
    if (col_q == CW'(COLS - 1)) begin
      nxt_col_s = {CW{1'b0}};
      nxt_row_s = row_q + RW'(1);
    end else begin
      nxt_col_s = col_q + CW'(1);
      nxt_row_s = row_q;
    end
    reach_s = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if ((hits_q[IW'(r * COLS + c)] != 2'd0) &&
            (10'(Y0) + 10'(r * Y_PITCH) + {2'b00, offset_q} + 10'(BRICK_H - 1) >= 10'(FLOOR_Y))) begin
          reach_s = 1'b1;
        end else begin
          reach_s = reach_s;
        end
      end
    end
  end

  // Frame sequencer: next-state for FSM, brick state and the registered pixel output stage.
  always_comb begin
    state_d       = state_q;
    hits_d        = hits_q;
    offset_d      = offset_q;
    ball_x_d      = ball_x_q;
    ball_y_d      = ball_y_q;
    lower_d       = lower_q;
    idx_d         = idx_q;
    row_d         = row_q;
    col_d         = col_q;
    px_d          = px_q;
    py_d          = py_q;
    plot_x_d      = plot_x_q;
    plot_y_d      = plot_y_q;
    plot_colour_d = plot_colour_q;
    bounce_d      = bounce_q;
    wall_d        = wall_q;
    left_d        = left_q;
    done_d        = 1'b0;
`ifdef BRICK_SCORE_EN
    score_d       = score_q;
`endif
    if (plot_valid_q && plot_ready) begin
      plot_valid_d = 1'b0;
    end else begin
      plot_valid_d = plot_valid_q;
    end
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ball_x_d = ball_x;
          ball_y_d = ball_y;
          lower_d  = lower;
          bounce_d = 1'b0;
          idx_d    = {IW{1'b0}};
          row_d    = {RW{1'b0}};
          col_d    = {CW{1'b0}};
          state_d  = S_CHECK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CHECK: begin
        if (hit_s) begin
          hits_d[idx_q] = cur_hits_s - 2'd1;
          bounce_d      = 1'b1;
          if (cur_hits_s == 2'd1) begin
            left_d = left_q - 8'd1;
`ifdef BRICK_SCORE_EN
            if (score_q != 16'hFFFF) begin
              score_d = score_q + 16'd1;
            end else begin
              score_d = score_q;
            end
`endif
          end else begin
            left_d = left_q;
          end
        end else begin
          bounce_d = bounce_q;
        end
        if (last_brick_s) begin
          idx_d   = {IW{1'b0}};
          row_d   = {RW{1'b0}};
          col_d   = {CW{1'b0}};
          px_d    = {PXW{1'b0}};
          py_d    = {PYW{1'b0}};
          state_d = lower_q ? S_ERASE : S_DRAW;
        end else begin
          idx_d = nxt_idx_s;
          row_d = nxt_row_s;
          col_d = nxt_col_s;
        end
      end
      S_ERASE, S_DRAW: begin
        // Off-screen pixels still consume their cycle but never raise valid.
        if (can_adv_s) begin
          if (on_screen_s) begin
            plot_valid_d  = 1'b1;
            plot_x_d      = pix_x_s[7:0];
            plot_y_d      = pix_y_s[7:0];
            plot_colour_d = (state_q == S_ERASE) ? 3'b000 : colour_of(cur_hits_s);
          end else begin
            plot_valid_d = 1'b0;
          end
          if (px_q != PXW'(BRICK_W - 1)) begin
            px_d = px_q + PXW'(1);
          end else if (!last_px_s) begin
            px_d = {PXW{1'b0}};
            py_d = py_q + PYW'(1);
          end else if (!last_brick_s) begin
            px_d  = {PXW{1'b0}};
            py_d  = {PYW{1'b0}};
            idx_d = nxt_idx_s;
            row_d = nxt_row_s;
            col_d = nxt_col_s;
          end else begin
            px_d  = {PXW{1'b0}};
            py_d  = {PYW{1'b0}};
            idx_d = {IW{1'b0}};
            row_d = {RW{1'b0}};
            col_d = {CW{1'b0}};
            if (state_q == S_ERASE) begin
              offset_d = offset_sum_s[8] ? 8'hFF : offset_sum_s[7:0];
              state_d  = S_DRAW;
            end else begin
              state_d = S_DONE;
            end
          end
        end else begin
          state_d = state_q;
        end
      end
      S_DONE: begin
        if (can_adv_s) begin
          wall_d  = wall_q | reach_s;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      for (int i = 0; i < N; i++) hits_q[i] <= 2'(HITS);
      offset_q      <= 8'd0;
      ball_x_q      <= 8'd0;
      ball_y_q      <= 8'd0;
      lower_q       <= 1'b0;
      idx_q         <= {IW{1'b0}};
      row_q         <= {RW{1'b0}};
      col_q         <= {CW{1'b0}};
      px_q          <= {PXW{1'b0}};
      py_q          <= {PYW{1'b0}};
      plot_valid_q  <= 1'b0;
      plot_x_q      <= 8'd0;
      plot_y_q      <= 8'd0;
      plot_colour_q <= 3'b000;
      bounce_q      <= 1'b0;
      wall_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      left_q        <= 8'(N);
`ifdef BRICK_SCORE_EN
      score_q       <= 16'd0;
`endif
    end else begin
      state_q       <= state_d;
      hits_q        <= hits_d;
      offset_q      <= offset_d;
      ball_x_q      <= ball_x_d;
      ball_y_q      <= ball_y_d;
      lower_q       <= lower_d;
      idx_q         <= idx_d;
      row_q         <= row_d;
      col_q         <= col_d;
      px_q          <= px_d;
      py_q          <= py_d;
      plot_valid_q  <= plot_valid_d;
      plot_x_q      <= plot_x_d;
      plot_y_q      <= plot_y_d;
      plot_colour_q <= plot_colour_d;
      bounce_q      <= bounce_d;
      wall_q        <= wall_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      left_q        <= left_d;
`ifdef BRICK_SCORE_EN
      score_q       <= score_d;
`endif
    end
  end
endmodule
